// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches 16-bit words from a combinational ROM,
// resolves jmp/br/nop locally and hands every other instruction to execute
// through a valid/ready handshake. Keeps a saturating count of issued
// instructions.
module fetch_unit #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        flag_valid,
    input  logic        zero_flag,
    output logic [3:0]  pc,
    output logic [7:0]  issue_count
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] BRWAIT = 2'd2;
    localparam logic [1:0] ISSUE  = 2'd3;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_BR  = 4'b1100;

    logic [1:0]  state;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  target;
    logic        accept;

    assign opcode   = ir[15:12];
    assign target   = ir[11:8];
    assign rom_addr = pc;

    // inst_valid is decoded straight from the state so that an asynchronous
    // reset drops it in the same instant the state returns to FETCH.
    assign inst_valid = (state == ISSUE);
    assign accept     = (state == ISSUE) && inst_ready;

    // Sequencer: state, program counter and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= rom_data;
                    pc    <= pc + 4'd1;
                    state <= DECODE;
                end
                DECODE: begin
                    if (opcode == OP_JMP) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (opcode == OP_BR) begin
                        state <= BRWAIT;
                    end else if (ir == 16'h0000) begin
                        state <= FETCH;
                    end else begin
                        state <= ISSUE;
                    end
                end
                BRWAIT: begin
                    // pc already points past the branch, so a not-taken
                    // branch simply falls through.
                    if (flag_valid) begin
                        if (zero_flag) begin
                            pc <= target;
                        end
                        state <= FETCH;
                    end
                end
                ISSUE: begin
                    if (inst_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Issue register: captured on entry to ISSUE and held afterwards, so it
    // shows the last issued instruction whenever nothing is being offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= 16'h0000;
        end else if (state == DECODE && opcode != OP_JMP && opcode != OP_BR
                     && ir != 16'h0000) begin
            inst <= ir;
        end
    end

    // Saturating count of accepted instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= 8'h00;
        end else if (accept && issue_count != 8'hFF) begin
            issue_count <= issue_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a fixed vector table, hand-written multi-cycle
// sequences and randomized programs checked against an instruction-level
// timing model.
module tb_fetch_unit;

    localparam int N = 300;

    logic        clk;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        flag_valid;
    logic        zero_flag;
    logic [3:0]  pc;
    logic [7:0]  issue_count;

    logic [15:0] rom [16];

    int checks = 0;
    int errors = 0;

    // per-cycle stimulus and expected trace for the random runs
    logic        rdy [N];
    logic        fv  [N];
    logic        zf  [N];
    logic        ev  [N];
    logic [15:0] ei  [N];
    logic [3:0]  ep  [N];
    logic [7:0]  ec  [N];

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_inst;
        logic [3:0]  exp_pc;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [12];

    assign rom_data = rom[rom_addr];

    fetch_unit #(.RESET_PC(4'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .flag_valid  (flag_valid),
        .zero_flag   (zero_flag),
        .pc          (pc),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a falling edge with rst low; the next rising edge
    // is the first FETCH.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_rom(input logic [15:0] w);
        for (int i = 0; i < 16; i++) rom[i] = w;
    endtask

    task automatic random_rom();
        int r;
        logic [15:0] w;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                w = 16'($urandom);
                w[15:12] = 4'h8;
            end else if (r < 30) begin
                w = 16'($urandom);
                w[15:12] = 4'hC;
            end else if (r < 38) begin
                w = 16'h0000;
            end else begin
                w = 16'($urandom);
                while (w[15:12] == 4'h8 || w[15:12] == 4'hC) w[15:12] = 4'($urandom);
                if (w == 16'h0000) w = 16'h0001;
            end
            rom[i] = w;
        end
    endtask

    // Instruction-level model: walks the program one instruction at a time,
    // works out from the stimulus how many cycles each instruction occupies
    // (fetch, decode, then waiting for flag_valid or inst_ready) and paints
    // the expected outputs over those cycles.
    task automatic build_model();
        int t, e, c, cnt;
        logic [3:0]  p, np, p1;
        logic [15:0] w, last;
        logic        issues;
        t = 0; p = 4'd0; last = 16'h0000; cnt = 0;
        while (t < N) begin
            w = rom[p];
            p1 = p + 4'd1;
            issues = 1'b0;
            if (w[15:12] == 4'h8) begin
                e = t + 1; np = w[11:8];
            end else if (w[15:12] == 4'hC) begin
                c = t + 2;
                while (c < N && !fv[c]) c++;
                e = c;
                np = (c < N && zf[c]) ? w[11:8] : p1;
            end else if (w == 16'h0000) begin
                e = t + 1; np = p1;
            end else begin
                c = t + 2;
                while (c < N && !rdy[c]) c++;
                e = c; np = p1; issues = 1'b1;
            end
            for (int k = t; k <= e && k < N; k++) begin
                ep[k] = (k == t) ? p : p1;
                ec[k] = 8'(cnt);
                if (issues && k >= t + 2) begin
                    ev[k] = 1'b1; ei[k] = w;
                end else begin
                    ev[k] = 1'b0; ei[k] = last;
                end
            end
            if (issues && e < N) begin
                if (cnt < 255) cnt++;
                last = w;
            end
            t = e + 1;
            p = np;
        end
    endtask

    task automatic br_case(input logic zflag, input logic [3:0] exp_next, input logic [15:0] exp_inst);
        clear_rom(16'h0000);
        rom[0]  = 16'hCA00;
        rom[1]  = 16'h2222;
        rom[10] = 16'h1111;
        inst_ready = 1'b1;
        flag_valid = 1'b1;
        zero_flag  = 1'b1;
        do_reset();
        step();                      // FETCH done, DECODE (flag ignored)
        flag_valid = 1'b0;
        step();                      // now in BRWAIT
        for (int i = 0; i < 5; i++) begin
            #1;
            check("br_wait_valid", inst_valid, 1'b0);
            check("br_wait_pc", pc, 4'd1);
            step();
        end
        flag_valid = 1'b1;
        zero_flag  = zflag;
        step();
        flag_valid = 1'b0;
        #1;
        check("br_next_pc", pc, exp_next);
        check("br_next_addr", rom_addr, exp_next);
        step();
        step();
        #1;
        check("br_target_valid", inst_valid, 1'b1);
        check("br_target_inst", inst, exp_inst);
    endtask

    initial begin
        rst = 1'b0;
        inst_ready = 1'b0;
        flag_valid = 1'b0;
        zero_flag  = 1'b0;
        clear_rom(16'h0000);

        // reset state while rst is held
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_valid", inst_valid, 1'b0);
        check("rst_pc", pc, 4'd0);
        check("rst_addr", rom_addr, 4'd0);
        check("rst_inst", inst, 16'h0000);
        check("rst_count", issue_count, 8'h00);

        // vector table: two issues then jmp 0 back to the start
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 4'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 4'd1, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 16'hB401, 4'd1, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 16'hB401, 4'd1, 8'd1};
        vecs[4]  = '{1'b1, 1'b0, 16'hB401, 4'd2, 8'd1};
        vecs[5]  = '{1'b1, 1'b1, 16'hA20F, 4'd2, 8'd1};
        vecs[6]  = '{1'b1, 1'b0, 16'hA20F, 4'd2, 8'd2};
        vecs[7]  = '{1'b1, 1'b0, 16'hA20F, 4'd3, 8'd2};
        vecs[8]  = '{1'b1, 1'b0, 16'hA20F, 4'd0, 8'd2};
        vecs[9]  = '{1'b1, 1'b0, 16'hA20F, 4'd1, 8'd2};
        vecs[10] = '{1'b1, 1'b1, 16'hB401, 4'd1, 8'd2};
        vecs[11] = '{1'b1, 1'b0, 16'hB401, 4'd1, 8'd3};
        rom[0] = 16'hB401;
        rom[1] = 16'hA20F;
        rom[2] = 16'h8000;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            inst_ready = vecs[i].ready;
            #1;
            check("tbl_valid", inst_valid, vecs[i].exp_valid);
            check("tbl_inst", inst, vecs[i].exp_inst);
            check("tbl_pc", pc, vecs[i].exp_pc);
            check("tbl_count", issue_count, vecs[i].exp_cnt);
            step();
        end

        // conditional branch taken / not taken
        br_case(1'b1, 4'd10, 16'h1111);
        br_case(1'b0, 4'd1, 16'h2222);

        // issue stall for 4 cycles
        clear_rom(16'h0000);
        rom[0] = 16'h3333;
        inst_ready = 1'b0;
        do_reset();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_valid", inst_valid, 1'b1);
            check("stall_inst", inst, 16'h3333);
            check("stall_count", issue_count, 8'd0);
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #1;
        check("stall_accept_count", issue_count, 8'd1);
        check("stall_accept_valid", inst_valid, 1'b0);
        step();
        step();
        #1;
        check("stall_count_single", issue_count, 8'd1);

        // pc wrap from 15 to 0
        clear_rom(16'h0000);
        rom[0]  = 16'h8F00;
        rom[15] = 16'h4444;
        inst_ready = 1'b1;
        do_reset();
        step();
        step();
        #1;
        check("wrap_addr15", rom_addr, 4'd15);
        step();
        #1;
        check("wrap_pc0", pc, 4'd0);
        step();
        #1;
        check("wrap_inst", inst, 16'h4444);
        check("wrap_valid", inst_valid, 1'b1);
        step();
        #1;
        check("wrap_next_addr", rom_addr, 4'd0);

        // jmp to itself never issues
        clear_rom(16'h0000);
        rom[0] = 16'h8000;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            #1;
            check("selfjmp_valid", inst_valid, 1'b0);
            step();
        end
        check("selfjmp_count", issue_count, 8'd0);

        // asynchronous reset in the middle of an offered issue
        clear_rom(16'h5555);
        inst_ready = 1'b1;
        do_reset();
        step();
        step();
        step();
        inst_ready = 1'b0;
        step();
        step();
        #1;
        check("arst_pre_valid", inst_valid, 1'b1);
        check("arst_pre_count", issue_count, 8'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", inst_valid, 1'b0);
        check("arst_pc", pc, 4'd0);
        check("arst_inst", inst, 16'h0000);
        check("arst_count", issue_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // saturation of the issue counter
        clear_rom(16'h1234);
        inst_ready = 1'b1;
        do_reset();
        repeat (3 * 254) step();
        #1;
        check("sat_fe", issue_count, 8'hFE);
        repeat (3) step();
        #1;
        check("sat_ff", issue_count, 8'hFF);
        repeat (6) step();
        #1;
        check("sat_hold", issue_count, 8'hFF);

        // randomized programs against the instruction-level model
        for (int r = 0; r < 3; r++) begin
            random_rom();
            for (int n = 0; n < N; n++) begin
                rdy[n] = ($urandom_range(0, 9) < 6);
                fv[n]  = ($urandom_range(0, 9) < 3);
                zf[n]  = 1'($urandom);
            end
            build_model();
            do_reset();
            for (int n = 0; n < N; n++) begin
                inst_ready = rdy[n];
                flag_valid = fv[n];
                zero_flag  = zf[n];
                #1;
                check("rnd_valid", inst_valid, ev[n]);
                check("rnd_inst", inst, ei[n]);
                check("rnd_pc", pc, ep[n]);
                check("rnd_addr", rom_addr, ep[n]);
                check("rnd_count", issue_count, ec[n]);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 4'd0, as the program counter value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port rom_addr, output, 4, the address driven to the program ROM (combinational ROM, data valid same cycle).
REQ-005 The block SHALL have port rom_data, input, 16, the instruction word returned by the ROM.
REQ-006 The block SHALL have port inst, output, 16, the instruction issued to execute.
REQ-007 The block SHALL have port inst_valid, output, 1, meaning inst is valid for issue.
REQ-008 The block SHALL have port inst_ready, input, 1, meaning execute accepts inst this cycle.
REQ-009 The block SHALL have port flag_valid, input, 1, meaning zero_flag reflects all previously issued instructions.
REQ-010 The block SHALL have port zero_flag, input, 1, the execute-stage zero flag.
REQ-011 The block SHALL have port pc, output, 4, the current program counter, for debug.
REQ-012 The block SHALL have port issue_count, output, 8, the number of instructions issued, saturating.

Function
REQ-013 The block SHALL implement FSM states FETCH, DECODE, BRWAIT and ISSUE.
REQ-014 rom_addr SHALL equal pc at all times.
REQ-015 FETCH SHALL latch rom_data into instruction register ir, set pc <= pc+1 (modulo 16, so 15 wraps to 0), and go to DECODE.
REQ-016 Opcode SHALL be ir[15:12]; control-transfer target SHALL be ir[11:8].
REQ-017 In DECODE, opcode 4'b1000 (jmp) SHALL set pc <= target, go to FETCH, and not be issued.
REQ-018 In DECODE, opcode 4'b1100 (br) SHALL go to BRWAIT and not be issued.
REQ-019 In DECODE, ir == 16'h0000 (nop) SHALL go to FETCH and not be issued.
REQ-020 In DECODE, every other instruction SHALL go to ISSUE.
REQ-021 BRWAIT SHALL hold until flag_valid=1; on that cycle zero_flag=1 SHALL set pc <= target, zero_flag=0 SHALL leave pc unchanged (fall-through), and the FSM SHALL go to FETCH.
REQ-022 In ISSUE, inst_valid SHALL be 1 and inst SHALL equal ir, held stable until inst_ready=1.
REQ-023 On the ISSUE cycle with inst_ready=1, the FSM SHALL go to FETCH and issue_count SHALL increment, saturating at 8'hFF.
REQ-024 inst_valid SHALL be 0 in all states other than ISSUE.
REQ-025 inst SHALL hold the last issued value outside ISSUE.
REQ-026 Latency for a non-control instruction SHALL be inst_valid asserted 2 cycles after the FETCH cycle (FETCH, DECODE, ISSUE).
REQ-027 A jmp SHALL cost 2 cycles.
REQ-028 A br SHALL cost 2 cycles plus the BRWAIT wait time.
REQ-029 A jmp to its own address SHALL loop indefinitely with no issue and no lockup of reset.
REQ-030 inst_ready high outside ISSUE SHALL be ignored.
REQ-031 flag_valid outside BRWAIT SHALL be ignored.

Reset
REQ-032 On rst=1, at any time including mid-handshake or in BRWAIT, the block SHALL immediately set state=FETCH, pc=RESET_PC, ir=0, inst=0, inst_valid=0 and issue_count=0.
REQ-033 After rst deasserts, the first FETCH SHALL occur on the first rising clk edge.

Verification
REQ-034 ROM[0]=16'hB401, ROM[1]=16'hA20F, inst_ready=1 -> inst=B401 with inst_valid on cycle 3, then inst=A20F on cycle 6, and issue_count=2.
REQ-035 ROM[2]=16'h8000 (jmp 0) -> no issue of 8000, pc=0 two cycles after its fetch, and the program repeats.
REQ-036 br 10 (16'hCA00) with flag_valid held low for 5 cycles then flag_valid=1 and zero_flag=1 -> pc=10 and the next fetch reads address 10; the same case with zero_flag=0 -> the next fetch reads br address+1.
REQ-037 inst_ready=0 for 4 cycles in ISSUE -> inst_valid and inst stable for all 4 cycles, and a single issue_count increment on acceptance.
REQ-038 pc=15 holding a non-control instruction -> pc wraps to 0 and the next fetch reads address 0.
REQ-039 rst pulsed asynchronously while in ISSUE with inst_valid=1 -> inst_valid=0 and pc=0 before the next clk edge, and issue_count=0.
